reg_wb_queue: RTL and testbench

Write-back queue that owns the writer side of the register file's single write port (RegWrite/WN/WD). It accepts results from two producers: the ALU path and the slower memory/multi-cycle path. It buffers them in a small in-order FIFO and drains one entry per granted cycle into the register file. It also exposes per-read-port pending-write status and forwarding data, so issue logic can stall or bypass against results that are not yet committed.

---
 rtl/reg_wb_queue_pkg.sv | 22 ++
 rtl/reg_wb_queue_if.sv | 53 +++++
 rtl/reg_wb_match.sv | 41 ++++
 rtl/reg_wb_queue.sv | 101 ++++++++++
 tb/tb_reg_wb_queue.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
//   wb_entry_t : one pending register write {wn, wd}
//   wb_src_e   : which producer wins the enqueue slot in a cycle
package reg_wb_queue_pkg;

   localparam int RN_W   = 5;
   localparam int DATA_W = 32;

   localparam logic [RN_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [RN_W-1:0]   wn;
      logic [DATA_W-1:0] wd;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_MEM,
      SRC_ALU
   } wb_src_e;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Bus bundle for reg_wb_queue.
//   producers : mem_* and alu_* valid/wn/wd in, *_ready out
//   write port: wp_en in, RegWrite/WN/WD out
//   lookup    : chk_rn1/2 in, busy1/2 and fwd_d1/2 out
//   status    : count, full, empty out
// master = the surrounding pipeline, slave = the queue.
interface reg_wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
);
   import reg_wb_queue_pkg::*;

   logic              mem_valid;
   logic [RN_W-1:0]   mem_wn;
   logic [DATA_W-1:0] mem_wd;
   logic              mem_ready;

   logic              alu_valid;
   logic [RN_W-1:0]   alu_wn;
   logic [DATA_W-1:0] alu_wd;
   logic              alu_ready;

   logic              wp_en;
   logic              RegWrite;
   logic [RN_W-1:0]   WN;
   logic [DATA_W-1:0] WD;

   logic [RN_W-1:0]   chk_rn1;
   logic [RN_W-1:0]   chk_rn2;
   logic              busy1;
   logic              busy2;
   logic [DATA_W-1:0] fwd_d1;
   logic [DATA_W-1:0] fwd_d2;

   logic [AW:0]       count;
   logic              full;
   logic              empty;

   modport master (
      output mem_valid, mem_wn, mem_wd, alu_valid, alu_wn, alu_wd,
             wp_en, chk_rn1, chk_rn2,
      input  mem_ready, alu_ready, RegWrite, WN, WD,
             busy1, busy2, fwd_d1, fwd_d2, count, full, empty
   );

   modport slave (
      input  mem_valid, mem_wn, mem_wd, alu_valid, alu_wn, alu_wd,
             wp_en, chk_rn1, chk_rn2,
      output mem_ready, alu_ready, RegWrite, WN, WD,
             busy1, busy2, fwd_d1, fwd_d2, count, full, empty
   );

endinterface

// File: rtl/reg_wb_match.sv
// Youngest-match lookup over the write-back queue storage.
//   entries : queue storage array (physical order)
//   head    : physical index of the oldest valid entry
//   count   : number of valid entries starting at head
//   chk_rn  : register number being checked
//   busy    : some valid entry targets chk_rn (never for r0)
//   fwd_d   : data of the youngest such entry, else 0
module reg_wb_match
   import reg_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wb_entry_t         entries [DEPTH],
   input  logic [AW-1:0]     head,
   input  logic [AW:0]       count,
   input  logic [RN_W-1:0]   chk_rn,
   output logic              busy,
   output logic [DATA_W-1:0] fwd_d
);

   logic [AW-1:0] idx;

   // Walk oldest to youngest so the last hit overwrites earlier ones.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before
      // any branch, otherwise an unassigned path infers a latch.
      busy  = 1'b0;
      fwd_d = '0;
      idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (((AW+1)'(k) < count) && (chk_rn != REG_ZERO) &&
             (entries[idx].wn == chk_rn)) begin
            busy  = 1'b1;
            fwd_d = entries[idx].wd;
         end
      end
   end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order write-back queue in front of the register file write port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_wb_queue_if.slave (producer handshakes, write port,
//              pending-write lookup, occupancy status)
// The memory path has fixed priority over the ALU path since it always
// completes the older instruction. Results for r0 are accepted and dropped.
module reg_wb_queue
   import reg_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   reg_wb_queue_if.slave  bus
);

   wb_entry_t entries [DEPTH];
   logic [AW:0] head;
   logic [AW:0] tail;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        enq;
   logic        pop;
   wb_src_e     src;
   wb_entry_t   in_entry;
   wb_entry_t   head_entry;

   // Pointers carry one extra wrap bit so full and empty are distinct.
   assign count = tail - head;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   assign bus.count = count;
   assign bus.full  = full;
   assign bus.empty = empty;

   // A full queue refuses even when a pop is happening this cycle.
   assign bus.mem_ready = ~full;
   assign bus.alu_ready = ~full & ~bus.mem_valid;

   always_comb begin
      src      = SRC_NONE;
      in_entry = '0;
      if (bus.mem_valid && !full) begin
         src         = SRC_MEM;
         in_entry.wn = bus.mem_wn;
         in_entry.wd = bus.mem_wd;
      end else if (bus.alu_valid && !full) begin
         src         = SRC_ALU;
         in_entry.wn = bus.alu_wn;
         in_entry.wd = bus.alu_wd;
      end
   end

   assign enq = (src != SRC_NONE) && (in_entry.wn != REG_ZERO);
   assign pop = ~empty & bus.wp_en;

   assign head_entry   = entries[head[AW-1:0]];
   assign bus.RegWrite = pop;
   assign bus.WN       = empty ? REG_ZERO : head_entry.wn;
   assign bus.WD       = empty ? '0       : head_entry.wd;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (enq) tail <= tail + (AW+1)'(1);
         if (pop) head <= head + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only observed
   // when the pointers mark it valid, and reset clears the pointers.
   always_ff @(posedge clk) begin
      if (enq) entries[tail[AW-1:0]] <= in_entry;
   end

   reg_wb_match #(.DEPTH(DEPTH), .AW(AW)) u_match1 (
      .entries (entries),
      .head    (head[AW-1:0]),
      .count   (count),
      .chk_rn  (bus.chk_rn1),
      .busy    (bus.busy1),
      .fwd_d   (bus.fwd_d1)
   );

   reg_wb_match #(.DEPTH(DEPTH), .AW(AW)) u_match2 (
      .entries (entries),
      .head    (head[AW-1:0]),
      .count   (count),
      .chk_rn  (bus.chk_rn2),
      .busy    (bus.busy2),
      .fwd_d   (bus.fwd_d2)
   );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue. Inputs change 1 time unit after
// posedge; combinational outputs are checked 1 unit later; register-file
// writes are collected on negedge and compared against a scoreboard fed
// when the bench offers a result it expects to be accepted.
module tb_reg_wb_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] wd;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;
   exp_t sb [$];

   reg_wb_queue_if #(.DEPTH(DEPTH)) bus ();

   reg_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.mem_valid = 1'b0;
      bus.mem_wn    = '0;
      bus.mem_wd    = '0;
      bus.alu_valid = 1'b0;
      bus.alu_wn    = '0;
      bus.alu_wd    = '0;
      bus.wp_en     = 1'b0;
      bus.chk_rn1   = '0;
      bus.chk_rn2   = '0;
   endtask

   // Offer one result for a single cycle, check its ready, and record it
   // as an expected write if it should be accepted and is not r0.
   task automatic offer(input bit is_mem, input logic [4:0] wn,
                        input logic [31:0] wd, input bit exp_ready);
      if (is_mem) begin
         bus.mem_valid = 1'b1;
         bus.mem_wn    = wn;
         bus.mem_wd    = wd;
      end else begin
         bus.alu_valid = 1'b1;
         bus.alu_wn    = wn;
         bus.alu_wd    = wd;
      end
      #1;
      if (is_mem) check("mem_ready", bus.mem_ready, exp_ready);
      else        check("alu_ready", bus.alu_ready, exp_ready);
      if (exp_ready && wn != 5'd0) sb.push_back('{wn: wn, wd: wd});
      step();
      if (is_mem) bus.mem_valid = 1'b0;
      else        bus.alu_valid = 1'b0;
   endtask

   // Register-file side: every RegWrite cycle must match the oldest
   // expected write.
   always @(negedge clk) begin
      if (bus.RegWrite) begin
         if (sb.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_wn", {27'd0, bus.WN}, {27'd0, e.wn});
            check("wr_wd", bus.WD, e.wd);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b0;
      clear_inputs();

      // Reset values, including alu_ready following mem_valid.
      #1 rst = 1'b1;
      #1;
      check("rst_regwrite", bus.RegWrite, 0);
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_mem_ready", bus.mem_ready, 1);
      check("rst_alu_ready", bus.alu_ready, 1);
      bus.mem_valid = 1'b1;
      #1;
      check("rst_alu_ready_memv", bus.alu_ready, 0);
      check("rst_mem_ready_memv", bus.mem_ready, 1);
      bus.mem_valid = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Single ALU write: visible the cycle after acceptance, then gone.
      bus.wp_en = 1'b1;
      offer(1'b0, 5'd5, 32'h1234, 1'b1);
      check("alu1_regwrite", bus.RegWrite, 1);
      check("alu1_wn", bus.WN, 5);
      check("alu1_wd", bus.WD, 32'h1234);
      check("alu1_count", bus.count, 1);
      step();
      check("alu1_empty", bus.empty, 1);
      check("alu1_regwrite_off", bus.RegWrite, 0);

      // Fill with the write port stalled, then drain in order.
      bus.wp_en = 1'b0;
      for (int i = 1; i <= 4; i++) offer(1'b1, 5'(i), 32'h100 + i, 1'b1);
      check("fill_full", bus.full, 1);
      check("fill_count", bus.count, 4);
      check("fill_regwrite_hold", bus.RegWrite, 0);
      check("fill_head_wn", bus.WN, 1);
      check("fill_head_wd", bus.WD, 32'h101);
      bus.wp_en = 1'b1;
      bus.alu_valid = 1'b1;
      bus.alu_wn = 5'd9;
      #0;
      check("full_alu_ready", bus.alu_ready, 0);
      bus.alu_valid = 1'b0;
      offer(1'b1, 5'd9, 32'h999, 1'b0);
      check("drain_count3", bus.count, 3);
      step();
      step();
      step();
      check("drain_empty", bus.empty, 1);

      // Arbitration: mem wins, alu follows; enq+pop keeps count.
      bus.mem_valid = 1'b1;
      bus.mem_wn    = 5'd10;
      bus.mem_wd    = 32'hAA;
      bus.alu_valid = 1'b1;
      bus.alu_wn    = 5'd11;
      bus.alu_wd    = 32'hBB;
      #1;
      check("arb_mem_ready", bus.mem_ready, 1);
      check("arb_alu_ready", bus.alu_ready, 0);
      sb.push_back('{wn: 5'd10, wd: 32'hAA});
      step();
      bus.mem_valid = 1'b0;
      #1;
      check("arb_alu_ready2", bus.alu_ready, 1);
      check("arb_count_a", bus.count, 1);
      sb.push_back('{wn: 5'd11, wd: 32'hBB});
      step();
      bus.alu_valid = 1'b0;
      check("arb_count_b", bus.count, 1);
      step();
      check("arb_empty", bus.empty, 1);

      // Zero register: accepted, never stored, never written.
      offer(1'b1, 5'd0, 32'hDEAD, 1'b1);
      check("r0_count", bus.count, 0);
      check("r0_empty", bus.empty, 1);
      check("r0_regwrite", bus.RegWrite, 0);

      // Hazard lookup and youngest-value forwarding.
      bus.wp_en   = 1'b0;
      bus.chk_rn1 = 5'd7;
      bus.chk_rn2 = 5'd3;
      offer(1'b1, 5'd3, 32'h33, 1'b1);
      bus.mem_valid = 1'b1;
      bus.mem_wn    = 5'd7;
      bus.mem_wd    = 32'hA;
      #1;
      check("hz_inflight_busy1", bus.busy1, 0);
      check("hz_inflight_fwd1", bus.fwd_d1, 0);
      sb.push_back('{wn: 5'd7, wd: 32'hA});
      step();
      bus.mem_valid = 1'b0;
      offer(1'b0, 5'd7, 32'hB, 1'b1);
      check("hz_busy1", bus.busy1, 1);
      check("hz_fwd1", bus.fwd_d1, 32'hB);
      check("hz_busy2_r3", bus.busy2, 1);
      check("hz_fwd2_r3", bus.fwd_d2, 32'h33);
      bus.chk_rn2 = 5'd0;
      #1;
      check("hz_busy2_r0", bus.busy2, 0);
      check("hz_fwd2_r0", bus.fwd_d2, 0);
      bus.wp_en = 1'b1;
      step();
      check("hz_pop1_busy1", bus.busy1, 1);
      check("hz_pop1_fwd1", bus.fwd_d1, 32'hB);
      step();
      check("hz_pop2_busy1", bus.busy1, 1);
      check("hz_pop2_fwd1", bus.fwd_d1, 32'hB);
      check("hz_pop2_busy2", bus.busy2, 0);
      step();
      check("hz_pop3_busy1", bus.busy1, 0);
      check("hz_pop3_fwd1", bus.fwd_d1, 0);
      check("hz_pop3_empty", bus.empty, 1);

      // Asynchronous reset in the middle of a drain.
      bus.wp_en   = 1'b0;
      bus.chk_rn1 = 5'd21;
      for (int i = 0; i < 4; i++) offer(1'b1, 5'(20 + i), 32'h2000 + i, 1'b1);
      bus.wp_en = 1'b1;
      step();
      check("mid_count3", bus.count, 3);
      check("mid_busy1", bus.busy1, 1);
      #2 rst = 1'b1;
      #1;
      sb.delete();
      check("arst_regwrite", bus.RegWrite, 0);
      check("arst_wn", bus.WN, 0);
      check("arst_wd", bus.WD, 0);
      check("arst_count", bus.count, 0);
      check("arst_empty", bus.empty, 1);
      check("arst_full", bus.full, 0);
      check("arst_busy1", bus.busy1, 0);
      check("arst_fwd1", bus.fwd_d1, 0);
      check("arst_mem_ready", bus.mem_ready, 1);
      check("arst_alu_ready", bus.alu_ready, 1);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      step();
      check("post_rst_empty", bus.empty, 1);
      check("post_rst_regwrite", bus.RegWrite, 0);

      clear_inputs();
      step();
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
